mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/acknowledge bus between an initiator and the
// word-organised memory responder. The initiator holds req with stable
// we/addr/wdata/wmask until it sees the one-cycle ack pulse.
interface mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] wmask;
   logic        ack;
   logic [31:0] rdata;
   logic        busy;
   logic        err;

   modport master (
      output req, we, addr, wdata, wmask,
      input  ack, rdata, busy, err
   );

   modport slave (
      input  req, we, addr, wdata, wmask,
      output ack, rdata, busy, err
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory with a programmable wait-state count
// and bit-masked writes. A request is latched in IDLE, the access commits after
// WAIT_STATES extra cycles, and ack pulses for one cycle in RESP.
// Optional feature macro: MEM_RESPONDER_ERR_CHECK_EN flags misaligned or
// out-of-range addresses (no write, rdata = 0, err = 1 in the ack cycle).
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input logic              clk1,
   input logic              rst,
   mem_responder_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [3:0]         cnt_r;
   logic [3:0]         cnt_next_s;
   logic               accept_s;
   logic               commit_s;

   logic               we_r;
   logic [IDX_W-1:0]   idx_r;
   logic [31:0]        wdata_r;
   logic [31:0]        wmask_r;
   logic               acc_err_r;
   logic               req_err_s;

   logic [31:0]        mem_r [DEPTH_WORDS];
   logic [31:0]        stored_s;
   logic [31:0]        merged_s;
   logic [31:0]        resp_data_s;

   logic               ack_r;
   logic               busy_r;
   logic               err_r;
   logic [31:0]        rdata_r;

   // Bit-masked merge: bits with mask = 1 take the new data, others keep the old word.
   function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [31:0] mask_w);
      return (old_w & ~mask_w) | (new_w & mask_w);
   endfunction

`ifdef MEM_RESPONDER_ERR_CHECK_EN
   localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
   assign req_err_s = (bus.addr[1:0] != 2'b00) || ({1'b0, bus.addr} >= ADDR_LIMIT);
`else
   // Low address bits are ignored and the index wraps modulo DEPTH_WORDS.
   assign req_err_s = 1'b0;
`endif

   assign stored_s = mem_r[idx_r];
   assign merged_s = merge_word(stored_s, wdata_r, wmask_r);

   // Next-state and wait-counter logic; decides acceptance and commit cycles.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      accept_s     = 1'b0;
      commit_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req) begin
               accept_s     = 1'b1;
               cnt_next_s   = 4'(WAIT_STATES);
               state_next_s = WAIT;
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r != 4'd0) begin
               cnt_next_s = cnt_r - 4'd1;
            end else begin
               commit_s     = 1'b1;
               state_next_s = RESP;
            end
         end
         RESP: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = 4'd0;
         end
      endcase
   end

   // Response word: zero on an error, merged word on a write, stored word on a read.
   always_comb begin
      resp_data_s = 32'h0000_0000;
      if (acc_err_r) begin
         resp_data_s = 32'h0000_0000;
      end else if (we_r) begin
         resp_data_s = merged_s;
      end else begin
         resp_data_s = stored_s;
      end
   end

   // State, counter, request latches and registered bus outputs.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= 4'd0;
         we_r      <= 1'b0;
         idx_r     <= '0;
         wdata_r   <= 32'h0000_0000;
         wmask_r   <= 32'h0000_0000;
         acc_err_r <= 1'b0;
         ack_r     <= 1'b0;
         busy_r    <= 1'b0;
         err_r     <= 1'b0;
         rdata_r   <= 32'h0000_0000;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         ack_r   <= commit_s;
         busy_r  <= (state_next_s != IDLE);
         err_r   <= commit_s & acc_err_r;
         if (accept_s) begin
            we_r      <= bus.we;
            idx_r     <= bus.addr[IDX_W+1:2];
            wdata_r   <= bus.wdata;
            wmask_r   <= bus.wmask;
            acc_err_r <= req_err_s;
         end
         if (commit_s) begin
            rdata_r <= resp_data_s;
         end
      end
   end

   // Memory array write port; contents are intentionally not reset.
   always_ff @(posedge clk1) begin
      if (commit_s && we_r && !acc_err_r) begin
         mem_r[idx_r] <= merged_s;
      end
   end

   assign bus.ack   = ack_r;
   assign bus.busy  = busy_r;
   assign bus.err   = err_r;
   assign bus.rdata = rdata_r;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench. Stimulus pushes {err, rdata} expectations
// into a queue per DUT; a monitor pops and compares on every ack.
// dut  : WAIT_STATES = 2 (latency, masking, latching, reset, error checks)
// dut0 : WAIT_STATES = 0 (back-to-back requests with req held high)
module tb_mem_responder;
   localparam int WS = 2;

   logic clk1 = 1'b0;
   logic rst  = 1'b1;

   int checks = 0;
   int passes = 0;

   logic [32:0] exp_q  [$];
   logic [32:0] exp0_q [$];

   mem_responder_if bus ();
   mem_responder_if bus0 ();

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
   );

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus0)
   );

   always #5 clk1 = ~clk1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor for the WAIT_STATES=2 instance.
   always @(negedge clk1) begin
      if (bus.ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("dut_unexpected_ack", 32'd1, 32'd0);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("dut_rdata", bus.rdata, e[31:0]);
            check("dut_err", {31'd0, bus.err}, {31'd0, e[32]});
         end
      end
   end

   // Scoreboard monitor for the WAIT_STATES=0 instance.
   always @(negedge clk1) begin
      if (bus0.ack === 1'b1) begin
         if (exp0_q.size() == 0) begin
            check("dut0_unexpected_ack", 32'd1, 32'd0);
         end else begin
            logic [32:0] e;
            e = exp0_q.pop_front();
            check("dut0_rdata", bus0.rdata, e[31:0]);
            check("dut0_err", {31'd0, bus0.err}, {31'd0, e[32]});
         end
      end
   end

   // One transaction on dut; inputs switch to a_wait/d_wait during WAIT.
   task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] m, input logic [31:0] a_wait,
                            input logic [31:0] d_wait, input logic [31:0] exp_rd,
                            input logic exp_err);
      int lat;
      @(negedge clk1);
      bus.req   = 1'b1;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      bus.wmask = m;
      exp_q.push_back({exp_err, exp_rd});
      @(posedge clk1);
      @(negedge clk1);
      lat = 1;
      check("busy_rise", {31'd0, bus.busy}, 32'd1);
      bus.addr  = a_wait;
      bus.wdata = d_wait;
      while (bus.ack !== 1'b1 && lat < 20) begin
         @(negedge clk1);
         lat++;
      end
      check("ack_latency", lat, WS + 2);
      bus.req = 1'b0;
      @(negedge clk1);
      check("busy_fall", {31'd0, bus.busy}, 32'd0);
      check("ack_one_cycle", {31'd0, bus.ack}, 32'd0);
   endtask

   // Watchdog: a hung run still reports and stops.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        w0    [6];
      logic [31:0] a0    [6];
      logic [31:0] d0    [6];
      logic [31:0] e0    [6];

      w0 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      a0 = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h4};
      d0 = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 32'h0, 32'h0};
      e0 = '{32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222,
             32'h1111_1111, 32'h2222_2222};

      bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = 32'h0;  bus.wdata = 32'h0;  bus.wmask = 32'h0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0; bus0.wmask = 32'h0;

      // Reset values
      #12;
      check("rst_ack", {31'd0, bus.ack}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      check("rst_rdata", bus.rdata, 32'h0);
      @(negedge clk1);
      rst = 1'b0;

      // Full write and read-back at 0x0
      do_access(1'b1, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0);
      do_access(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
      repeat (3) @(negedge clk1);
      check("rdata_hold", bus.rdata, 32'h1234_5678);

      // Masked write, then zero-mask write
      do_access(1'b1, 32'h4, 32'h1234_5678, 32'hFFFF_FFFF, 32'h4, 32'h1234_5678, 32'h1234_5678, 1'b0);
      do_access(1'b1, 32'h4, 32'hAAAA_AAAA, 32'h0000_FFFF, 32'h4, 32'hAAAA_AAAA, 32'h1234_AAAA, 1'b0);
      do_access(1'b0, 32'h4, 32'h0, 32'h0, 32'h4, 32'h0, 32'h1234_AAAA, 1'b0);
      do_access(1'b1, 32'h4, 32'hFFFF_FFFF, 32'h0, 32'h4, 32'hFFFF_FFFF, 32'h1234_AAAA, 1'b0);
      do_access(1'b0, 32'h4, 32'h0, 32'h0, 32'h4, 32'h0, 32'h1234_AAAA, 1'b0);

      // Inputs changing during WAIT are ignored
      do_access(1'b1, 32'h8, 32'h8888_8888, 32'hFFFF_FFFF, 32'h8, 32'h8888_8888, 32'h8888_8888, 1'b0);
      do_access(1'b1, 32'h4, 32'h4444_4444, 32'hFFFF_FFFF, 32'h8, 32'h9999_9999, 32'h4444_4444, 1'b0);
      do_access(1'b0, 32'h8, 32'h0, 32'h0, 32'h8, 32'h0, 32'h8888_8888, 1'b0);
      do_access(1'b0, 32'h4, 32'h0, 32'h0, 32'h4, 32'h0, 32'h4444_4444, 1'b0);

      // Reset one cycle after accepting a write: no ack, no memory change
      do_access(1'b1, 32'hC, 32'h0C0F_FEE0, 32'hFFFF_FFFF, 32'hC, 32'h0C0F_FEE0, 32'h0C0F_FEE0, 1'b0);
      @(negedge clk1);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'hC; bus.wdata = 32'hDEAD_BEEF; bus.wmask = 32'hFFFF_FFFF;
      @(posedge clk1);
      @(negedge clk1);
      rst = 1'b1;
      bus.req = 1'b0;
      #1;
      check("midrst_ack", {31'd0, bus.ack}, 32'd0);
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_rdata", bus.rdata, 32'h0);
      repeat (4) @(negedge clk1);
      check("midrst_no_ack", {31'd0, bus.ack}, 32'd0);
      rst = 1'b0;
      do_access(1'b0, 32'hC, 32'h0, 32'h0, 32'hC, 32'h0, 32'h0C0F_FEE0, 1'b0);

`ifdef MEM_RESPONDER_ERR_CHECK_EN
      do_access(1'b1, 32'h2, 32'h5555_5555, 32'hFFFF_FFFF, 32'h2, 32'h5555_5555, 32'h0, 1'b1);
      do_access(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
      do_access(1'b1, 32'h1000, 32'h6666_6666, 32'hFFFF_FFFF, 32'h1000, 32'h6666_6666, 32'h0, 1'b1);
      do_access(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
`else
      do_access(1'b0, 32'h1000, 32'h0, 32'h0, 32'h1000, 32'h0, 32'h1234_5678, 1'b0);
`endif

      // WAIT_STATES = 0, req held high: WAIT, RESP(ack), IDLE repeating
      @(negedge clk1);
      bus0.req = 1'b1; bus0.we = w0[0]; bus0.addr = a0[0]; bus0.wdata = d0[0]; bus0.wmask = 32'hFFFF_FFFF;
      exp0_q.push_back({1'b0, e0[0]});
      @(posedge clk1);
      for (int t = 0; t < 6; t++) begin
         @(negedge clk1);
         check("ws0_wait_busy", {31'd0, bus0.busy}, 32'd1);
         check("ws0_wait_ack", {31'd0, bus0.ack}, 32'd0);
         @(negedge clk1);
         check("ws0_resp_ack", {31'd0, bus0.ack}, 32'd1);
         check("ws0_resp_busy", {31'd0, bus0.busy}, 32'd1);
         if (t < 5) begin
            bus0.we = w0[t+1]; bus0.addr = a0[t+1]; bus0.wdata = d0[t+1];
            exp0_q.push_back({1'b0, e0[t+1]});
         end else begin
            bus0.req = 1'b0;
         end
         @(negedge clk1);
         check("ws0_idle_busy", {31'd0, bus0.busy}, 32'd0);
         check("ws0_idle_ack", {31'd0, bus0.ack}, 32'd0);
      end

      repeat (3) @(negedge clk1);
      check("dut_queue_drained", exp_q.size(), 32'd0);
      check("dut0_queue_drained", exp0_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
